// File: rtl/alu_pkg.sv
// ==== alu_pkg: shared word type and width for the Y86-64 ALU blocks | rev 1.0 ====
`default_nettype none

package alu_pkg;
  localparam int WORD_W = 64;
  typedef logic signed [WORD_W-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ==== full_adder: one-bit full adder cell for the ripple-carry chain | rev 1.0 ====
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/adder_64.sv
// ==== adder_64: registered 64-bit ripple-carry adder with carry/overflow flags | rev 1.0 ====
`default_nettype none

module adder_64
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  output logic [63:0] sum,
  output logic        carry,
  output logic        overflow
);

  word_t a_w;
  word_t b_w;
  word_t s_n;
  logic  carry_n;
  logic  overflow_n;

  assign a_w = word_t'(a);
  assign b_w = word_t'(b);

  // Each stage owns its carry pair so the chain is a set of scalar nets, not one self-referencing vector.
  for (genvar i = 0; i < WORD_W; i++) begin : g_fa
    logic cin;
    logic cout;
    if (i == 0) begin : g_lsb
      assign cin = 1'b0;
    end else begin : g_chain
      assign cin = g_fa[i-1].cout;
    end
    full_adder u_fa (
      .a    (a_w[i]),
      .b    (b_w[i]),
      .cin  (cin),
      .s    (s_n[i]),
      .cout (cout)
    );
  end

  assign carry_n    = g_fa[WORD_W-1].cout;
  assign overflow_n = (a_w[WORD_W-1] == b_w[WORD_W-1]) && (s_n[WORD_W-1] != a_w[WORD_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      sum       <= s_n;
      carry     <= carry_n;
      overflow  <= overflow_n;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_64.sv
// ==== tb_adder_64: directed vectors for adder_64 against an arithmetic reference | rev 1.0 ====
`default_nettype none

module tb_adder_64;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic [63:0] sum;
  logic        carry;
  logic        overflow;

  int vectors;
  int miscompares;

  adder_64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 65-bit unsigned and signed sums.
  logic        exp_valid;
  logic [63:0] exp_sum;
  logic        exp_carry;
  logic        exp_ovf;

  always @(posedge clk or negedge rst_n) begin
    logic [64:0] us;
    logic [64:0] ss;
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_sum   <= '0;
      exp_carry <= 1'b0;
      exp_ovf   <= 1'b0;
    end else begin
      exp_valid <= in_valid;
      if (in_valid) begin
        us = {1'b0, a} + {1'b0, b};
        ss = {a[63], a} + {b[63], b};
        exp_sum   <= us[63:0];
        exp_carry <= us[64];
        exp_ovf   <= (ss[64] != ss[63]);
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (out_valid !== exp_valid || sum !== exp_sum || carry !== exp_carry || overflow !== exp_ovf) begin
      miscompares++;
      $display("FAIL model t=%0t: got v=%b s=%h c=%b o=%b, want v=%b s=%h c=%b o=%b",
               $time, out_valid, sum, carry, overflow, exp_valid, exp_sum, exp_carry, exp_ovf);
    end
  end

  task automatic check_lit(input string name, input logic v, input logic [63:0] s,
                           input logic c, input logic o);
    vectors++;
    if (out_valid !== v || sum !== s || carry !== c || overflow !== o) begin
      miscompares++;
      $display("FAIL %s: got v=%b s=%h c=%b o=%b, want v=%b s=%h c=%b o=%b",
               name, out_valid, sum, carry, overflow, v, s, c, o);
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    vecs[0] = '{"all_ones",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
    vecs[1] = '{"small_neg", 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFF4, 1'b1, 1'b0};
    vecs[2] = '{"mid_zeros", 64'hFFFF_FFFF_EFFF_FFFE, 64'hFFFF_FFFF_DFFF_FFFD, 64'hFFFF_FFFF_CFFF_FFFB, 1'b1, 1'b0};
    vecs[3] = '{"pos_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1};
    vecs[4] = '{"neg_ovf",   64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b1, 1'b1};
    vecs[5] = '{"min_min",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #1;
    check_lit("reset_state", 1'b0, 64'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back valid inputs, one result per cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = vecs[i].a;
      b        = vecs[i].b;
      @(posedge clk);
      #1;
      check_lit(vecs[i].name, 1'b1, vecs[i].s, vecs[i].c, vecs[i].o);
    end

    @(negedge clk);
    in_valid = 1'b0;
    a        = 64'h1234_5678_9ABC_DEF0;
    b        = 64'h0FED_CBA9_8765_4321;
    @(posedge clk);
    #1;
    check_lit("idle_hold", 1'b0, 64'h0, 1'b1, 1'b1);

    @(negedge clk);
    in_valid = 1'b1;
    a        = 64'h0000_0000_0000_0005;
    b        = 64'h0000_0000_0000_0007;
    @(posedge clk);
    #1;
    check_lit("small_pos", 1'b1, 64'h0000_0000_0000_000C, 1'b0, 1'b0);

    // Asynchronous reset between edges, with in_valid still high.
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = 64'h0000_0000_0000_0001;
    #2;
    rst_n = 1'b0;
    #1;
    check_lit("async_reset", 1'b0, 64'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_lit("reset_held", 1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_lit("first_after_reset", 1'b1, 64'h0, 1'b1, 1'b0);

    // A few extra operand patterns for the reference comparison.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = (i % 3) != 2;
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
